// File: rtl/loop_nest_counter_pkg.sv
// Shared definitions for the nested loop counter.
//   state_t   : controller FSM encoding (IDLE / RUN / DONE)
//   LEVELS_DEF, WIDTH_DEF : default geometry (3 levels x 4 bits)
//   BUS_W_DEF : packed bound/count bus width, LEVELS*WIDTH
package counter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam int LEVELS_DEF = 3;
  localparam int WIDTH_DEF  = 4;
  localparam int BUS_W_DEF  = LEVELS_DEF * WIDTH_DEF;
endpackage

// File: rtl/loop_nest_counter_if.sv
// Handshake/bus bundle between the CNN controller and loop_nest_counter.
//   master : controller side (drives start/step/clr/bound_i)
//   slave  : counter side (drives count_o/wrap_o/last_o/done_o/busy_o)
// Level k occupies [k*WIDTH +: WIDTH] of bound_i and count_o.
interface loop_nest_counter_if #(
  parameter int LEVELS = counter_pkg::LEVELS_DEF,
  parameter int WIDTH  = counter_pkg::WIDTH_DEF
);
  logic                      start;
  logic                      step;
  logic                      clr;
  logic [LEVELS*WIDTH-1:0]   bound_i;
  logic [LEVELS*WIDTH-1:0]   count_o;
  logic [LEVELS-1:0]         wrap_o;
  logic                      last_o;
  logic                      done_o;
  logic                      busy_o;

  modport master (
    output start, step, clr, bound_i,
    input  count_o, wrap_o, last_o, done_o, busy_o
  );

  modport slave (
    input  start, step, clr, bound_i,
    output count_o, wrap_o, last_o, done_o, busy_o
  );
endinterface

// File: rtl/loop_nest_counter_stage.sv
// One level of the nested loop counter.
//   clk, rst_n : clock, async active-low reset
//   clr, load  : synchronous zeroing (abort / start of run)
//   carry_in   : advance this level this cycle
//   bnd        : latched bound (>=1 while running); counts 0..bnd-1
//   count      : current value
//   at_max     : count == bnd-1
//   carry_out  : carry_in & at_max, i.e. this level wraps on this cycle
module counter_stage #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic             carry_in,
  input  logic [WIDTH-1:0] bnd,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             carry_out
);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_top;

  assign w_top     = bnd - ONE;
  assign at_max    = (r_count == w_top);
  assign carry_out = carry_in & at_max;
  assign count     = r_count;

  // Wrapping at bnd-1 keeps the count below bnd, so it can never overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              r_count <= '0;
    else if (clr || load)    r_count <= '0;
    else if (carry_in) begin
      if (at_max)            r_count <= '0;
      else                   r_count <= r_count + ONE;
    end
  end
endmodule

// File: rtl/loop_nest_counter.sv
// Runtime-bounded N-level nested loop counter for CNN address generation.
//   clk, rst_n : clock, async active-low reset
//   bus.start  : latch bounds and zero counts (IDLE only)
//   bus.step   : advance one iteration (RUN only)
//   bus.clr    : synchronous abort to IDLE, beats start/step
//   bus.bound_i: per-level bounds, a bound of 0 is treated as 1
//   bus.count_o: per-level counts
//   bus.wrap_o : combinational, level k wraps on this step
//   bus.last_o : combinational, RUN and every level at bound-1
//   bus.done_o : one-cycle pulse (DONE state) after the final step
//   bus.busy_o : high while in RUN
module loop_nest_counter
  import counter_pkg::*;
#(
  parameter int LEVELS = LEVELS_DEF,
  parameter int WIDTH  = WIDTH_DEF
) (
  input logic               clk,
  input logic               rst_n,
  loop_nest_counter_if.slave bus
);
  state_t                         r_state;
  state_t                         w_state_nxt;
  logic [LEVELS-1:0][WIDTH-1:0]   r_bnd;
  logic [LEVELS-1:0][WIDTH-1:0]   w_count;
  logic [LEVELS-1:0]              w_at_max;
  logic [LEVELS:0]                w_carry;
  logic                           w_run;
  logic                           w_load;
  logic                           w_final;

  assign w_run   = (r_state == RUN);
  assign w_load  = (r_state == IDLE) && bus.start && !bus.clr;
  // Carry into level 0 is the qualified step; the chain ripples up from there.
  assign w_carry[0] = w_run && bus.step;
  assign w_final    = w_carry[LEVELS];

  // Bounds are sampled only on an accepted start, so bound_i may move freely
  // during RUN/DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bnd <= '0;
    end else if (w_load) begin
      for (int k = 0; k < LEVELS; k++) begin
        if (bus.bound_i[k*WIDTH +: WIDTH] == '0)
          r_bnd[k] <= {{(WIDTH-1){1'b0}}, 1'b1};
        else
          r_bnd[k] <= bus.bound_i[k*WIDTH +: WIDTH];
      end
    end
  end

  for (genvar k = 0; k < LEVELS; k++) begin : g_stage
    counter_stage #(.WIDTH(WIDTH)) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (bus.clr),
      .load      (w_load),
      .carry_in  (w_carry[k]),
      .bnd       (r_bnd[k]),
      .count     (w_count[k]),
      .at_max    (w_at_max[k]),
      .carry_out (w_carry[k+1])
    );
  end

  assign bus.count_o = w_count;
  assign bus.wrap_o  = w_carry[LEVELS:1];
  assign bus.last_o  = w_run && (&w_at_max);

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM: next state. The carry out of the top level is exactly the final step.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.clr) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (bus.start) w_state_nxt = RUN;
        RUN:     if (w_final)   w_state_nxt = DONE;
        DONE:                   w_state_nxt = IDLE;
        default:                w_state_nxt = IDLE;
      endcase
    end
  end

  // FSM: outputs, decoded from the registered state
  always_comb begin
    bus.busy_o = 1'b0;
    bus.done_o = 1'b0;
    case (r_state)
      RUN:     bus.busy_o = 1'b1;
      DONE:    bus.done_o = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_loop_nest_counter.sv
module tb_loop_nest_counter;
  import counter_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  loop_nest_counter_if #(.LEVELS(3), .WIDTH(4)) bus();
  loop_nest_counter #(.LEVELS(3), .WIDTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Expected packed counts after n steps with effective bounds e0,e1,e2.
  function automatic logic [11:0] exp_cnt(int n, int e0, int e1, int e2);
    logic [3:0] c0, c1, c2;
    c0 = 4'(n % e0);
    c1 = 4'((n / e0) % e1);
    c2 = 4'((n / (e0 * e1)) % e2);
    return {c2, c1, c0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.step = 1'b0; bus.clr = 1'b0; bus.bound_i = '0;
    #12;
    checks++;
    if (bus.count_o !== 12'h000 || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 ||
        bus.wrap_o !== 3'b000 || bus.last_o !== 1'b0) begin
      errors++;
      $display("FAIL reset count=%h busy=%b done=%b wrap=%b last=%b, want 000 0 0 000 0",
               bus.count_o, bus.busy_o, bus.done_o, bus.wrap_o, bus.last_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // One complete run with per-step checks of counts, wrap_o, last_o, done_o.
  task automatic run_config(input int b0, input int b1, input int b2,
                            input int gap, input bit chg, input string tag);
    int e0, e1, e2, n_tot;
    logic [2:0] ew;
    e0 = (b0 == 0) ? 1 : b0;
    e1 = (b1 == 0) ? 1 : b1;
    e2 = (b2 == 0) ? 1 : b2;
    n_tot = e0 * e1 * e2;
    bus.bound_i = {4'(b2), 4'(b1), 4'(b0)};
    bus.step = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.busy_o !== 1'b1 || bus.count_o !== 12'h000) begin
      errors++;
      $display("FAIL %s_start busy=%b count=%h, want 1 000", tag, bus.busy_o, bus.count_o);
    end
    for (int s = 1; s <= n_tot; s++) begin
      for (int g = 1; g < gap; g++) begin
        tick();
        checks++;
        if (bus.count_o !== exp_cnt(s-1, e0, e1, e2) || bus.wrap_o !== 3'b000) begin
          errors++;
          $display("FAIL %s_hold%0d count=%h wrap=%b, want %h 000", tag, s,
                   bus.count_o, bus.wrap_o, exp_cnt(s-1, e0, e1, e2));
        end
      end
      if (chg && s == n_tot / 2) bus.bound_i = 12'h777;
      bus.step = 1'b1;
      #1;
      ew = {(s % (e0*e1*e2)) == 0, (s % (e0*e1)) == 0, (s % e0) == 0};
      checks++;
      if (bus.wrap_o !== ew || bus.last_o !== (s == n_tot)) begin
        errors++;
        $display("FAIL %s_wrap%0d wrap=%b last=%b, want %b %b", tag, s,
                 bus.wrap_o, bus.last_o, ew, (s == n_tot));
      end
      tick();
      bus.step = 1'b0;
      if (s < n_tot) begin
        checks++;
        if (bus.count_o !== exp_cnt(s, e0, e1, e2) || bus.busy_o !== 1'b1 || bus.done_o !== 1'b0) begin
          errors++;
          $display("FAIL %s_cnt%0d count=%h busy=%b done=%b, want %h 1 0", tag, s,
                   bus.count_o, bus.busy_o, bus.done_o, exp_cnt(s, e0, e1, e2));
        end
      end
    end
    checks++;
    if (bus.done_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.count_o !== 12'h000) begin
      errors++;
      $display("FAIL %s_done done=%b busy=%b count=%h, want 1 0 000", tag,
               bus.done_o, bus.busy_o, bus.count_o);
    end
    tick();
    checks++;
    if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_after done=%b busy=%b, want 0 0", tag, bus.done_o, bus.busy_o);
    end
  endtask

  task automatic test_full_run();
    run_config(4, 2, 3, 1, 1'b0, "full");
  endtask

  task automatic test_gapped();
    run_config(4, 2, 3, 3, 1'b1, "gapped");
  endtask

  task automatic test_zero_max();
    run_config(15, 0, 2, 1, 1'b0, "zeromax");
  endtask

  task automatic test_abort();
    bus.bound_i = 12'h324;
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    for (int s = 1; s <= 4; s++) begin
      bus.step = 1'b1; tick(); bus.step = 1'b0;
    end
    checks++;
    if (bus.count_o !== 12'h010) begin
      errors++;
      $display("FAIL abort_pre count=%h, want 010", bus.count_o);
    end
    bus.step = 1'b1; bus.clr = 1'b1;
    tick();
    bus.step = 1'b0; bus.clr = 1'b0;
    checks++;
    if (bus.busy_o !== 1'b0 || bus.count_o !== 12'h000 || bus.done_o !== 1'b0) begin
      errors++;
      $display("FAIL abort busy=%b count=%h done=%b, want 0 000 0",
               bus.busy_o, bus.count_o, bus.done_o);
    end
    tick();
    checks++;
    if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle done=%b busy=%b, want 0 0", bus.done_o, bus.busy_o);
    end
    run_config(4, 2, 3, 1, 1'b0, "restart");
  endtask

  task automatic test_ignored();
    bus.bound_i = 12'h324;
    bus.step = 1'b1;
    #1;
    checks++;
    if (bus.wrap_o !== 3'b000 || bus.last_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_step_comb wrap=%b last=%b, want 000 0", bus.wrap_o, bus.last_o);
    end
    tick(); tick();
    bus.step = 1'b0;
    checks++;
    if (bus.count_o !== 12'h000 || bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_step count=%h busy=%b, want 000 0", bus.count_o, bus.busy_o);
    end
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    for (int s = 1; s <= 3; s++) begin
      bus.step = 1'b1; tick(); bus.step = 1'b0;
    end
    bus.bound_i = 12'h111;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.count_o !== 12'h003 || bus.busy_o !== 1'b1) begin
      errors++;
      $display("FAIL run_start count=%h busy=%b, want 003 1", bus.count_o, bus.busy_o);
    end
    for (int s = 4; s <= 23; s++) begin
      bus.step = 1'b1; tick(); bus.step = 1'b0;
    end
    bus.step = 1'b1; bus.clr = 1'b1;
    #1;
    checks++;
    if (bus.last_o !== 1'b1 || bus.count_o !== 12'h213) begin
      errors++;
      $display("FAIL clr_final_pre last=%b count=%h, want 1 213", bus.last_o, bus.count_o);
    end
    tick();
    bus.step = 1'b0; bus.clr = 1'b0;
    checks++;
    if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.count_o !== 12'h000) begin
      errors++;
      $display("FAIL clr_final done=%b busy=%b count=%h, want 0 0 000",
               bus.done_o, bus.busy_o, bus.count_o);
    end
    tick();
    checks++;
    if (bus.done_o !== 1'b0) begin
      errors++;
      $display("FAIL clr_final_next done=%b, want 0", bus.done_o);
    end
  endtask

  task automatic test_async_reset();
    bus.bound_i = 12'h324;
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    for (int s = 1; s <= 5; s++) begin
      bus.step = 1'b1; tick(); bus.step = 1'b0;
    end
    checks++;
    if (bus.count_o !== 12'h011) begin
      errors++;
      $display("FAIL areset_pre count=%h, want 011", bus.count_o);
    end
    bus.step = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.count_o !== 12'h000 || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 ||
        bus.wrap_o !== 3'b000 || bus.last_o !== 1'b0) begin
      errors++;
      $display("FAIL areset count=%h busy=%b done=%b wrap=%b last=%b, want 000 0 0 000 0",
               bus.count_o, bus.busy_o, bus.done_o, bus.wrap_o, bus.last_o);
    end
    bus.step = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.busy_o !== 1'b0 || bus.count_o !== 12'h000) begin
      errors++;
      $display("FAIL areset_idle busy=%b count=%h, want 0 000", bus.busy_o, bus.count_o);
    end
    run_config(4, 2, 3, 1, 1'b0, "post_reset");
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_gapped();
    test_zero_max();
    test_abort();
    test_ignored();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
